// File: rtl/maxunpool2d.sv
`default_nettype none
// ============================================================================
// Module   : maxunpool2d
// Purpose  : Streaming 2x2 max-unpool for float32 words. Each pooled word is
//            expanded into a 2x2 window (value at its winner position, +0.0
//            elsewhere); the unpooled map is emitted in raster order.
//            Optional build macro: MAXUNPOOL_ABS_EN (clears bit 31 of every
//            routed value).
// Revision : 1.0 - initial release
// ============================================================================
module maxunpool2d #(
    parameter int IN_W = 14
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_idx,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_eol
);

    localparam int             CW     = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam logic [CW-1:0]  C_LAST = CW'(IN_W - 1);

    typedef enum logic [0:0] {
        S_TOP = 1'b0,
        S_BOT = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_col;
    logic [CW-1:0]  w_col_nxt;
    logic           r_phase;
    logic           w_phase_nxt;
    logic [31:0]    r_out_data;
    logic [31:0]    w_out_data_nxt;
    logic           r_out_valid;
    logic           w_out_valid_nxt;
    logic           r_out_eol;
    logic           w_out_eol_nxt;

    // Entries are {value[31:0], idx[1:0]}.
    logic [33:0]    r_hold;
    logic [33:0]    r_buf [IN_W];
    logic [33:0]    w_rd;

    logic           w_slot_free;
    logic           w_in_fire;

    function automatic logic [31:0] f_route(input logic [31:0] v);
`ifdef MAXUNPOOL_ABS_EN
        return {1'b0, v[30:0]};
`else
        return v;
`endif
    endfunction

    assign w_slot_free = !r_out_valid || out_ready;
    assign in_ready    = (r_state == S_TOP) && !r_phase && w_slot_free;
    assign w_in_fire   = in_valid && in_ready;
    assign w_rd        = r_buf[r_col];

    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign out_eol     = r_out_eol;

    always_comb begin
        w_state_nxt     = r_state;
        w_col_nxt       = r_col;
        w_phase_nxt     = r_phase;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = r_out_valid;
        w_out_eol_nxt   = r_out_eol;

        if (r_state == S_TOP) begin
            if (!r_phase) begin
                if (w_in_fire) begin
                    w_out_data_nxt  = (in_idx == 2'd0) ? f_route(in_data) : 32'h0000_0000;
                    w_out_valid_nxt = 1'b1;
                    w_out_eol_nxt   = 1'b0;
                    w_phase_nxt     = 1'b1;
                end else if (w_slot_free) begin
                    // Starved input: let the register drain rather than repeat a word.
                    w_out_valid_nxt = 1'b0;
                    w_out_eol_nxt   = 1'b0;
                end
            end else if (w_slot_free) begin
                w_out_data_nxt  = (r_hold[1:0] == 2'd1) ? f_route(r_hold[33:2]) : 32'h0000_0000;
                w_out_valid_nxt = 1'b1;
                w_phase_nxt     = 1'b0;
                if (r_col == C_LAST) begin
                    w_out_eol_nxt = 1'b1;
                    w_col_nxt     = '0;
                    w_state_nxt   = S_BOT;
                end else begin
                    w_out_eol_nxt = 1'b0;
                    w_col_nxt     = r_col + 1'b1;
                end
            end
        end else if (w_slot_free) begin
            // Bottom row: phase selects the left (idx 2) or right (idx 3) word.
            w_out_data_nxt  = (w_rd[1:0] == {1'b1, r_phase}) ? f_route(w_rd[33:2]) : 32'h0000_0000;
            w_out_valid_nxt = 1'b1;
            w_phase_nxt     = !r_phase;
            w_out_eol_nxt   = 1'b0;
            if (r_phase) begin
                if (r_col == C_LAST) begin
                    w_out_eol_nxt = 1'b1;
                    w_col_nxt     = '0;
                    w_state_nxt   = S_TOP;
                end else begin
                    w_col_nxt     = r_col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_TOP;
            r_col       <= '0;
            r_phase     <= 1'b0;
            r_out_data  <= 32'h0000_0000;
            r_out_valid <= 1'b0;
            r_out_eol   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_col       <= w_col_nxt;
            r_phase     <= w_phase_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_eol   <= w_out_eol_nxt;
        end
    end

    // Line buffer and hold register carry no reset: BOT only reads a fully written row.
    always_ff @(posedge Clk) begin
        if (w_in_fire) begin
            r_hold       <= {in_data, in_idx};
            r_buf[r_col] <= {in_data, in_idx};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_maxunpool2d.sv
`default_nettype none
// ============================================================================
// Module   : tb_maxunpool2d
// Purpose  : Self-checking bench for maxunpool2d at IN_W = 1, 2, 4 and 14.
// Revision : 1.0 - initial release
// ============================================================================
module tb_maxunpool2d;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [31:0] s_in_data  [4];
    logic [1:0]  s_in_idx   [4];
    logic        s_in_valid [4];
    logic        s_in_ready [4];
    logic [31:0] s_out_data [4];
    logic        s_out_valid[4];
    logic        s_out_ready[4];
    logic        s_out_eol  [4];

    int checks   = 0;
    int failures = 0;

    maxunpool2d #(.IN_W(1)) u_dut0 (
        .Clk(Clk), .Reset_n(Reset_n), .in_data(s_in_data[0]), .in_idx(s_in_idx[0]),
        .in_valid(s_in_valid[0]), .in_ready(s_in_ready[0]), .out_data(s_out_data[0]),
        .out_valid(s_out_valid[0]), .out_ready(s_out_ready[0]), .out_eol(s_out_eol[0]));
    maxunpool2d #(.IN_W(2)) u_dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .in_data(s_in_data[1]), .in_idx(s_in_idx[1]),
        .in_valid(s_in_valid[1]), .in_ready(s_in_ready[1]), .out_data(s_out_data[1]),
        .out_valid(s_out_valid[1]), .out_ready(s_out_ready[1]), .out_eol(s_out_eol[1]));
    maxunpool2d #(.IN_W(4)) u_dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .in_data(s_in_data[2]), .in_idx(s_in_idx[2]),
        .in_valid(s_in_valid[2]), .in_ready(s_in_ready[2]), .out_data(s_out_data[2]),
        .out_valid(s_out_valid[2]), .out_ready(s_out_ready[2]), .out_eol(s_out_eol[2]));
    maxunpool2d #(.IN_W(14)) u_dut3 (
        .Clk(Clk), .Reset_n(Reset_n), .in_data(s_in_data[3]), .in_idx(s_in_idx[3]),
        .in_valid(s_in_valid[3]), .in_ready(s_in_ready[3]), .out_data(s_out_data[3]),
        .out_valid(s_out_valid[3]), .out_ready(s_out_ready[3]), .out_eol(s_out_eol[3]));

    initial forever #5 Clk = ~Clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    function automatic int wk(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return 14;
        endcase
    endfunction

    function automatic logic [31:0] route(input logic [31:0] v);
`ifdef MAXUNPOOL_ABS_EN
        return v & 32'h7FFF_FFFF;
`else
        return v;
`endif
    endfunction

    task automatic check(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%h required=%h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    // ---------------- reference model: expected output stream per instance ----
    logic [31:0] e_data [4][256];
    logic        e_eol  [4][256];
    logic        e_bot  [4][256];
    logic [7:0]  head   [4];
    logic [7:0]  tail   [4];
    int          pend_bot[4];
    int          row_cnt [4];
    int          xfer    [4];
    logic [31:0] row_v  [4][14];
    logic [1:0]  row_i  [4][14];
    logic [31:0] log_d  [4][256];
    logic        log_e  [4][256];
    logic        prev_stall[4];
    logic [31:0] prev_data [4];
    logic        prev_eol  [4];
    int          rmode[4];
    int          fr_on = 0;
    int          fr_valid_cyc;
    int          fr_gaps;
    logic [31:0] mv;
    logic [1:0]  mi;
    logic [7:0]  hp;

    task automatic push(input int k, input logic [31:0] d, input logic e, input logic b);
        e_data[k][tail[k]] = d;
        e_eol[k][tail[k]]  = e;
        e_bot[k][tail[k]]  = b;
        tail[k]            = tail[k] + 8'd1;
    endtask

    always @(negedge Clk) begin
        if (!Reset_n) begin
            for (int k = 0; k < 4; k++) begin
                head[k] = '0; tail[k] = '0; pend_bot[k] = 0; row_cnt[k] = 0; xfer[k] = 0;
                prev_stall[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                // Two or more unsent bottom-row words mean the block is mid-BOT.
                if (pend_bot[k] >= 2)
                    check("in_ready_in_bot", k, 64'(s_in_ready[k]), 64'd0);
                if (prev_stall[k]) begin
                    check("stall_valid", k, 64'(s_out_valid[k]), 64'd1);
                    check("stall_data", k, 64'(s_out_data[k]), 64'(prev_data[k]));
                    check("stall_eol", k, 64'(s_out_eol[k]), 64'(prev_eol[k]));
                end
                prev_stall[k] = s_out_valid[k] && !s_out_ready[k];
                prev_data[k]  = s_out_data[k];
                prev_eol[k]   = s_out_eol[k];
                if (s_out_valid[k] && s_out_ready[k]) begin
                    if (head[k] == tail[k]) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output dut%0d actual=%h required=none", k, s_out_data[k]);
                    end else begin
                        hp = head[k];
                        check("out_data", k, 64'(s_out_data[k]), 64'(e_data[k][hp]));
                        check("out_eol", k, 64'(s_out_eol[k]), 64'(e_eol[k][hp]));
                        if (e_bot[k][hp]) pend_bot[k]--;
                        head[k] = head[k] + 8'd1;
                    end
                    log_d[k][8'(xfer[k])] = s_out_data[k];
                    log_e[k][8'(xfer[k])] = s_out_eol[k];
                    xfer[k]++;
                end
                if (s_in_valid[k] && s_in_ready[k]) begin
                    mv = route(s_in_data[k]);
                    mi = s_in_idx[k];
                    row_v[k][row_cnt[k]] = mv;
                    row_i[k][row_cnt[k]] = mi;
                    push(k, (mi == 2'd0) ? mv : 32'd0, 1'b0, 1'b0);
                    push(k, (mi == 2'd1) ? mv : 32'd0, row_cnt[k] == wk(k) - 1, 1'b0);
                    row_cnt[k]++;
                    if (row_cnt[k] == wk(k)) begin
                        for (int c = 0; c < wk(k); c++) begin
                            push(k, (row_i[k][c] == 2'd2) ? row_v[k][c] : 32'd0, 1'b0, 1'b1);
                            push(k, (row_i[k][c] == 2'd3) ? row_v[k][c] : 32'd0, c == wk(k) - 1, 1'b1);
                        end
                        pend_bot[k] += 2 * wk(k);
                        row_cnt[k]  = 0;
                    end
                end
            end
        end
        if (fr_on == 0) begin
            fr_valid_cyc = 0;
            fr_gaps      = 0;
        end else if (s_out_valid[3]) begin
            fr_valid_cyc++;
        end else if (fr_valid_cyc > 0 && fr_valid_cyc < 560) begin
            fr_gaps++;
        end
    end

    // ---------------- out_ready driver ----------------
    initial begin
        int cyc;
        cyc = 0;
        for (int k = 0; k < 4; k++) begin
            s_out_ready[k] = 1'b1;
            rmode[k]       = 0;
        end
        forever begin
            @(posedge Clk);
            #1;
            cyc++;
            for (int k = 0; k < 4; k++) begin
                case (rmode[k])
                    1:       s_out_ready[k] = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                    2:       s_out_ready[k] = 1'($urandom % 2);
                    default: s_out_ready[k] = 1'b1;
                endcase
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int k, input logic [31:0] d, input logic [1:0] ix);
        bit done;
        done          = 1'b0;
        s_in_data[k]  = d;
        s_in_idx[k]   = ix;
        s_in_valid[k] = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge Clk);
            if (s_in_ready[k]) done = 1'b1;
            @(posedge Clk);
            #1;
        end
        s_in_valid[k] = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout dut%0d actual=in_ready_low required=accept", k);
        end
    endtask

    task automatic wait_xfer(input int k, input int n);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 5000 && !done; t++) begin
            if (xfer[k] >= n) done = 1'b1;
            else @(posedge Clk);
        end
        #1;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL xfer_timeout dut%0d actual=%0d required=%0d", k, xfer[k], n);
        end
    endtask

    task automatic rand_rows(input int k, input int nrows, input int gaps);
        int g;
        for (int i = 0; i < nrows * wk(k); i++) begin
            send(k, $urandom, 2'($urandom % 4));
            g = (gaps != 0) ? int'($urandom_range(0, 3)) : 0;
            repeat (g) begin
                @(posedge Clk);
                #1;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] lit [8];
        logic [31:0] v1;
        int          base;

        Reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_in_valid[k] = 1'b0;
            s_in_data[k]  = '0;
            s_in_idx[k]   = '0;
        end
        #2 Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check("reset_out_valid", k, 64'(s_out_valid[k]), 64'd0);
            check("reset_out_data", k, 64'(s_out_data[k]), 64'd0);
            check("reset_out_eol", k, 64'(s_out_eol[k]), 64'd0);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        for (int k = 0; k < 4; k++)
            check("in_ready_after_reset", k, 64'(s_in_ready[k]), 64'd1);

        // Basic window, IN_W = 2
        base = xfer[1];
        send(1, 32'h3F80_0000, 2'd0);
        send(1, 32'h4000_0000, 2'd3);
        wait_xfer(1, base + 8);
        lit = '{32'h3F80_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4000_0000};
        for (int i = 0; i < 8; i++) begin
            check("basic_data", 1, 64'(log_d[1][8'(base + i)]), 64'(lit[i]));
            check("basic_eol", 1, 64'(log_e[1][8'(base + i)]), 64'((i == 3) || (i == 7)));
        end

        // All positions, IN_W = 1
`ifdef MAXUNPOOL_ABS_EN
        v1 = 32'h4040_0000;
`else
        v1 = 32'hC040_0000;
`endif
        base = xfer[0];
        send(0, 32'hC040_0000, 2'd1);
        send(0, 32'hC040_0000, 2'd2);
        wait_xfer(0, base + 8);
        lit = '{32'h0, v1, 32'h0, 32'h0, 32'h0, 32'h0, v1, 32'h0};
        for (int i = 0; i < 8; i++) begin
            check("w1_data", 0, 64'(log_d[0][8'(base + i)]), 64'(lit[i]));
            check("w1_eol", 0, 64'(log_e[0][8'(base + i)]), 64'(i % 2 == 1));
        end

        // Backpressure 1,0,0,1 over 3 rows of IN_W = 4
        rmode[2] = 1;
        base = xfer[2];
        rand_rows(2, 3, 0);
        wait_xfer(2, base + 48);
        rmode[2] = 2;
        base = xfer[2];
        rand_rows(2, 3, 1);
        wait_xfer(2, base + 48);
        rmode[2] = 0;

        // Random traffic on IN_W = 1 and IN_W = 14
        rmode[0] = 2;
        base = xfer[0];
        rand_rows(0, 6, 1);
        wait_xfer(0, base + 24);
        rmode[0] = 0;
        rmode[3] = 2;
        base = xfer[3];
        rand_rows(3, 2, 1);
        wait_xfer(3, base + 112);
        rmode[3] = 0;

        // Input starvation between words
        base = xfer[2];
        for (int c = 0; c < 4; c++) begin
            send(2, $urandom, 2'($urandom % 4));
            if (c < 3) begin
                repeat (2) @(posedge Clk);
                #1;
                check("starve_valid_drop", 2, 64'(s_out_valid[2]), 64'd0);
                check("starve_no_bot", 2, 64'(xfer[2] - base), 64'(2 * (c + 1)));
                repeat (3) @(posedge Clk);
                #1;
            end
        end
        wait_xfer(2, base + 16);

        // Reset mid-row
        send(2, $urandom, 2'($urandom % 4));
        send(2, $urandom, 2'($urandom % 4));
        send(2, $urandom, 2'($urandom % 4));
        #1 Reset_n = 1'b0;
        #1;
        check("async_reset_valid", 2, 64'(s_out_valid[2]), 64'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        check("reset_release_in_ready", 2, 64'(s_in_ready[2]), 64'd1);
        base = xfer[2];
        rand_rows(2, 1, 0);
        wait_xfer(2, base + 16);
        repeat (8) @(posedge Clk);
        #1;
        check("fresh_row_count", 2, 64'(xfer[2] - base), 64'd16);

        // Full rate: 10 rows of IN_W = 14
        fr_on = 1;
        base  = xfer[3];
        rand_rows(3, 10, 0);
        wait_xfer(3, base + 560);
        repeat (4) @(posedge Clk);
        #1;
        check("full_rate_valid_cycles", 3, 64'(fr_valid_cyc), 64'd560);
        check("full_rate_gaps", 3, 64'(fr_gaps), 64'd0);
        fr_on = 0;

        for (int k = 0; k < 4; k++)
            check("model_drained", k, 64'(tail[k] - head[k]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
